// File: rtl/osc_pkg.sv
// Shared types, state encoding and per-mode oscillator init tables for osc_scheduler.
package osc_pkg;

  localparam int MODE_W      = 4;
  localparam int OSC_TABLE_N = 4;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_WAIT   = 2'd3
  } osc_state_t;

  localparam logic [31:0] OSC_INIT1 [OSC_TABLE_N] = '{
    32'd96_878_045, 32'd189_803_872, 32'd277_450_213, 32'd357_913_941
  };
  localparam logic [31:0] OSC_INIT2 [OSC_TABLE_N] = '{
    32'd1_054_193_702, 32'd1_030_659_124, 32'd992_317_546, 32'd940_333_107
  };

  // Modes beyond the table length reuse entries cyclically.
  function automatic logic [31:0] osc_init1(input logic [MODE_W-1:0] mode);
    int idx;
    idx = int'(mode) % OSC_TABLE_N;
    return OSC_INIT1[idx];
  endfunction

  function automatic logic [31:0] osc_init2(input logic [MODE_W-1:0] mode);
    int idx;
    idx = int'(mode) % OSC_TABLE_N;
    return OSC_INIT2[idx];
  endfunction

endpackage

// File: rtl/osc_scheduler_if.sv
// Control/data bundle between osc_scheduler (master) and the oscillator DDS core (slave).
interface osc_scheduler_if;
  // Enable rises to request one step and stays high until Ready is sampled high,
  // dropping the following cycle; Ready seen with no request outstanding is ignored.
  // Load is a one-cycle strobe that qualifies Init1/Init2.
  logic        Enable;
  logic        Ready;
  logic        Load;
  logic [31:0] Init1;
  logic [31:0] Init2;

  modport master (output Enable, Load, Init1, Init2, input Ready);
  modport slave  (input Enable, Load, Init1, Init2, output Ready);
endinterface

// File: rtl/osc_btn_edge.sv
// Button register, rising-edge detect and lockout; emits one accepted-edge strobe.
module osc_btn_edge #(
  parameter int LOCKOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_accept
);

  localparam int LOCK_W = $clog2(LOCKOUT + 1);

  logic              r_btn_q;
  logic [LOCK_W-1:0] r_lock;
  logic              w_edge;

  assign w_edge   = i_btn & ~r_btn_q;
  assign o_accept = w_edge && (r_lock == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_q <= 1'b0;
      r_lock  <= '0;
    end else begin
      r_btn_q <= i_btn;
      if (o_accept) begin
        r_lock <= LOCK_W'(LOCKOUT);
      end else if (r_lock != '0) begin
        r_lock <= r_lock - 1'b1;
      end
    end
  end

endmodule

// File: rtl/osc_scheduler.sv
// Sample-rate sequencer for the oscillator DDS core: reload, settle, step, flag valid samples.
// Optional wait watchdog with sticky Timeout output when OSC_SCHED_WATCHDOG_EN is defined.
module osc_scheduler
  import osc_pkg::*;
#(
  parameter int NUM_MODES  = 4,
  parameter int TICK_DIV   = 500,
  parameter int SETTLE_CNT = 8,
  parameter int LOCKOUT    = 1024
`ifdef OSC_SCHED_WATCHDOG_EN
  , parameter int TIMEOUT  = 64
`endif
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              IntBTN,
  osc_scheduler_if.master   osc,
  output logic [MODE_W-1:0] Mode,
  output logic              Sample_Valid,
  output logic              Overrun,
`ifdef OSC_SCHED_WATCHDOG_EN
  output logic              Timeout,
`endif
  output osc_state_t        o_dbg_state
);

  osc_state_t        r_state, w_state_nxt;
  logic              r_enable, w_enable_nxt;
  logic              r_load, w_load_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic [MODE_W-1:0] r_mode, w_mode_nxt, w_mode_inc;
  logic [31:0]       r_init1, w_init1_nxt;
  logic [31:0]       r_init2, w_init2_nxt;
  logic [15:0]       r_settle, w_settle_nxt;
  logic              r_from_run, w_from_run_nxt;
  logic [15:0]       r_tick;
  logic              w_tick;
  logic              w_btn_accept;

`ifdef OSC_SCHED_WATCHDOG_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              r_timeout, w_timeout_nxt;
`endif

  osc_btn_edge #(.LOCKOUT(LOCKOUT)) u_btn (
    .clk      (Fg_CLK),
    .rst_n    (RESETn),
    .i_btn    (IntBTN),
    .o_accept (w_btn_accept)
  );

  // Free-running sample tick, independent of mode changes.
  assign w_tick     = (r_tick == 16'(TICK_DIV - 1));
  assign w_mode_inc = (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_enable_nxt   = r_enable;
    w_load_nxt     = 1'b0;
    w_valid_nxt    = 1'b0;
    w_overrun_nxt  = r_overrun;
    w_mode_nxt     = r_mode;
    w_init1_nxt    = r_init1;
    w_init2_nxt    = r_init2;
    w_settle_nxt   = r_settle;
    w_from_run_nxt = r_from_run;
`ifdef OSC_SCHED_WATCHDOG_EN
    w_wait_nxt     = '0;
    w_timeout_nxt  = r_timeout;
`endif
    // An accepted button edge overrides any tick, Ready or timeout in the same cycle.
    if (w_btn_accept) begin
      w_mode_nxt   = w_mode_inc;
      w_init1_nxt  = osc_init1(w_mode_inc);
      w_init2_nxt  = osc_init2(w_mode_inc);
      w_state_nxt  = S_LOAD;
      w_enable_nxt = 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          w_load_nxt   = 1'b1;
          w_enable_nxt = 1'b0;
          w_settle_nxt = 16'(SETTLE_CNT);
          w_state_nxt  = (SETTLE_CNT == 0) ? S_RUN : S_SETTLE;
        end
        S_SETTLE, S_RUN: begin
          if (w_tick) begin
            w_enable_nxt   = 1'b1;
            w_from_run_nxt = (r_state == S_RUN);
            w_state_nxt    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_tick) begin
            w_overrun_nxt = 1'b1;
          end
          if (osc.Ready) begin
            w_enable_nxt = 1'b0;
            if (r_from_run) begin
              w_valid_nxt = 1'b1;
              w_state_nxt = S_RUN;
            end else begin
              w_settle_nxt = r_settle - 1'b1;
              w_state_nxt  = (r_settle == 16'd1) ? S_RUN : S_SETTLE;
            end
          end
`ifdef OSC_SCHED_WATCHDOG_EN
          else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            w_enable_nxt  = 1'b0;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_LOAD;
          end else begin
            w_wait_nxt = r_wait + 1'b1;
          end
`endif
        end
        default: w_state_nxt = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      r_state    <= S_LOAD;
      r_enable   <= 1'b0;
      r_load     <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_mode     <= '0;
      r_init1    <= osc_init1('0);
      r_init2    <= osc_init2('0);
      r_settle   <= '0;
      r_from_run <= 1'b0;
      r_tick     <= '0;
`ifdef OSC_SCHED_WATCHDOG_EN
      r_wait     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_enable   <= w_enable_nxt;
      r_load     <= w_load_nxt;
      r_valid    <= w_valid_nxt;
      r_overrun  <= w_overrun_nxt;
      r_mode     <= w_mode_nxt;
      r_init1    <= w_init1_nxt;
      r_init2    <= w_init2_nxt;
      r_settle   <= w_settle_nxt;
      r_from_run <= w_from_run_nxt;
      r_tick     <= w_tick ? '0 : r_tick + 1'b1;
`ifdef OSC_SCHED_WATCHDOG_EN
      r_wait     <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
`endif
    end
  end

  assign osc.Enable   = r_enable;
  assign osc.Load     = r_load;
  assign osc.Init1    = r_init1;
  assign osc.Init2    = r_init2;
  assign Mode         = r_mode;
  assign Sample_Valid = r_valid;
  assign Overrun      = r_overrun;
  assign o_dbg_state  = r_state;
`ifdef OSC_SCHED_WATCHDOG_EN
  assign Timeout      = r_timeout;
`endif

endmodule

// File: tb/tb_osc_scheduler.sv
// Self-checking bench for osc_scheduler; Load events are scored against an expected queue.
`timescale 1ns/1ps
module tb_osc_scheduler;

  localparam int TICK_DIV   = 500;
  localparam int SETTLE_CNT = 8;
  localparam int LOCKOUT    = 1024;
  localparam int NUM_MODES  = 4;
  localparam int EXP_W      = 68;

  localparam logic [31:0] T_INIT1 [4] = '{
    32'd96_878_045, 32'd189_803_872, 32'd277_450_213, 32'd357_913_941
  };
  localparam logic [31:0] T_INIT2 [4] = '{
    32'd1_054_193_702, 32'd1_030_659_124, 32'd992_317_546, 32'd940_333_107
  };

  logic Fg_CLK = 1'b0;
  logic RESETn = 1'b0;
  logic IntBTN = 1'b0;
  logic [3:0] Mode;
  logic Sample_Valid;
  logic Overrun;
  osc_pkg::osc_state_t dbg_state;
`ifdef OSC_SCHED_WATCHDOG_EN
  logic Timeout;
`endif

  osc_scheduler_if osc ();

  osc_scheduler dut (
    .Fg_CLK       (Fg_CLK),
    .RESETn       (RESETn),
    .IntBTN       (IntBTN),
    .osc          (osc.master),
    .Mode         (Mode),
    .Sample_Valid (Sample_Valid),
    .Overrun      (Overrun),
`ifdef OSC_SCHED_WATCHDOG_EN
    .Timeout      (Timeout),
`endif
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / global time limit ----------------
  always #10 Fg_CLK = ~Fg_CLK;

  initial begin
    #(90_000 * 20);
    $display("FAIL global_time_limit: simulation did not finish within 90000 cycles");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_item;
  int   cyc      = 0;
  int   sv_count = 0;
  int   en_count = 0;
  int   sv_last  = 0;
  int   sv_prev  = 0;
  logic en_prev  = 1'b0;
  bit   ready_auto = 1'b1;
  logic [3:0] exp_mode = 4'd0;

  function automatic logic [3:0] next_mode(input logic [3:0] m);
    return (int'(m) == NUM_MODES - 1) ? 4'd0 : m + 4'd1;
  endfunction

  // Monitor: counts Enable rises and Sample_Valid pulses; scores every Load.
  initial begin
    forever begin
      @(negedge Fg_CLK);
      cyc++;
      if (osc.Enable === 1'b1 && en_prev !== 1'b1) en_count++;
      en_prev = osc.Enable;
      if (Sample_Valid === 1'b1) begin
        sv_count++;
        sv_prev = sv_last;
        sv_last = cyc;
      end
      if (osc.Load === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL load_unexpected: got load mode=%0d init1=%0d, expected no load", Mode, osc.Init1);
        end else begin
          exp_item = exp_q.pop_front();
          if ({Mode, osc.Init1, osc.Init2} !== exp_item)
            $display("FAIL load_values: got mode=%0d init1=%0d init2=%0d, expected mode=%0d init1=%0d init2=%0d",
                     Mode, osc.Init1, osc.Init2, exp_item[67:64], exp_item[63:32], exp_item[31:0]);
          else n_pass++;
        end
      end
    end
  end

  // Oscillator model: answers each request with a one-cycle Ready, 3 cycles after Enable.
  initial begin
    forever begin
      @(negedge Fg_CLK);
      if (ready_auto && osc.Enable === 1'b1 && osc.Ready === 1'b0) begin
        repeat (2) @(negedge Fg_CLK);
        if (ready_auto) begin
          osc.Ready = 1'b1;
          @(negedge Fg_CLK);
          osc.Ready = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_en(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && en_count < target; i++) @(negedge Fg_CLK);
    ok = (en_count >= target);
  endtask

  task automatic wait_sv(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && sv_count < target; i++) @(negedge Fg_CLK);
    ok = (sv_count >= target);
  endtask

  task automatic pulse_btn();
    exp_mode = next_mode(exp_mode);
    exp_q.push_back({exp_mode, T_INIT1[exp_mode], T_INIT2[exp_mode]});
    @(negedge Fg_CLK);
    IntBTN = 1'b1;
    @(negedge Fg_CLK);
    IntBTN = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESETn = 1'b0;
    IntBTN = 1'b0;
    repeat (4) @(negedge Fg_CLK);
    n_checks++; if (osc.Enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", osc.Enable); else n_pass++;
    n_checks++; if (osc.Load !== 1'b0) $display("FAIL reset_load: got %b expected 0", osc.Load); else n_pass++;
    n_checks++; if (Sample_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Sample_Valid); else n_pass++;
    n_checks++; if (Overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", Overrun); else n_pass++;
    n_checks++; if (Mode !== 4'd0) $display("FAIL reset_mode: got %0d expected 0", Mode); else n_pass++;
    n_checks++; if (osc.Init1 !== 32'd96_878_045) $display("FAIL reset_init1: got %0d expected 96878045", osc.Init1); else n_pass++;
    n_checks++; if (osc.Init2 !== 32'd1_054_193_702) $display("FAIL reset_init2: got %0d expected 1054193702", osc.Init2); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
    exp_q.push_back({4'd0, T_INIT1[0], T_INIT2[0]});
    RESETn = 1'b1;
    @(negedge Fg_CLK);
    n_checks++; if (osc.Load !== 1'b1) $display("FAIL release_load: got %b expected 1", osc.Load); else n_pass++;
  endtask

  task automatic test_settle_run();
    int en0, sv0;
    bit ok;
    en0 = en_count;
    sv0 = sv_count;
    wait_en(en0 + SETTLE_CNT, (SETTLE_CNT + 1) * TICK_DIV + 100, ok);
    n_checks++; if (!ok) $display("FAIL settle_steps_timeout: got %0d enables expected %0d", en_count - en0, SETTLE_CNT); else n_pass++;
    repeat (8) @(negedge Fg_CLK);
    n_checks++; if (sv_count !== sv0) $display("FAIL settle_no_valid: got %0d valids expected 0", sv_count - sv0); else n_pass++;
    wait_sv(sv0 + 1, 2 * TICK_DIV, ok);
    n_checks++; if (!ok) $display("FAIL first_valid_timeout: got %0d valids expected 1", sv_count - sv0); else n_pass++;
    n_checks++; if (en_count - en0 !== SETTLE_CNT + 1) $display("FAIL first_valid_step: got step %0d expected %0d", en_count - en0, SETTLE_CNT + 1); else n_pass++;
    wait_sv(sv0 + 2, 2 * TICK_DIV, ok);
    n_checks++; if (!ok) $display("FAIL second_valid_timeout: got %0d valids expected 2", sv_count - sv0); else n_pass++;
    n_checks++; if (sv_last - sv_prev !== TICK_DIV) $display("FAIL valid_spacing: got %0d expected %0d", sv_last - sv_prev, TICK_DIV); else n_pass++;
    n_checks++; if (Overrun !== 1'b0) $display("FAIL run_overrun: got %b expected 0", Overrun); else n_pass++;
  endtask

  task automatic test_button();
    int en0, sv0;
    bit ok;
    pulse_btn();
    n_checks++; if (Mode !== exp_mode) $display("FAIL btn_mode: got %0d expected %0d", Mode, exp_mode); else n_pass++;
    n_checks++; if (osc.Load !== 1'b0) $display("FAIL btn_load_early: got %b expected 0", osc.Load); else n_pass++;
    @(negedge Fg_CLK);
    n_checks++; if (osc.Load !== 1'b1) $display("FAIL btn_load: got %b expected 1", osc.Load); else n_pass++;
    en0 = en_count;
    sv0 = sv_count;
    wait_sv(sv0 + 1, (SETTLE_CNT + 2) * TICK_DIV, ok);
    n_checks++; if (!ok) $display("FAIL btn_valid_timeout: got %0d valids expected 1", sv_count - sv0); else n_pass++;
    n_checks++; if (en_count - en0 !== SETTLE_CNT + 1) $display("FAIL btn_settle_steps: got step %0d expected %0d", en_count - en0, SETTLE_CNT + 1); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      repeat (LOCKOUT + 76) @(negedge Fg_CLK);
      pulse_btn();
      n_checks++; if (Mode !== exp_mode) $display("FAIL btn_seq_mode: got %0d expected %0d", Mode, exp_mode); else n_pass++;
    end
    n_checks++; if (Mode !== 4'd0) $display("FAIL btn_wrap: got %0d expected 0", Mode); else n_pass++;
  endtask

  task automatic test_lockout();
    repeat (LOCKOUT + 76) @(negedge Fg_CLK);
    pulse_btn();
    repeat (100) @(negedge Fg_CLK);
    IntBTN = 1'b1;
    @(negedge Fg_CLK);
    IntBTN = 1'b0;
    repeat (200) @(negedge Fg_CLK);
    n_checks++; if (Mode !== exp_mode) $display("FAIL lockout_mode: got %0d expected %0d", Mode, exp_mode); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL lockout_load_pending: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_overrun();
    int sv1;
    bit ok;
    wait_sv(sv_count + 1, (SETTLE_CNT + 2) * TICK_DIV, ok);
    n_checks++; if (!ok) $display("FAIL ovr_run_timeout: got no valid expected 1"); else n_pass++;
    ready_auto = 1'b0;
    wait_en(en_count + 1, TICK_DIV + 50, ok);
    n_checks++; if (!ok) $display("FAIL ovr_enable_timeout: got no enable expected 1"); else n_pass++;
    sv1 = sv_count;
    repeat (600) @(negedge Fg_CLK);
    n_checks++; if (osc.Enable !== 1'b1) $display("FAIL ovr_enable_held: got %b expected 1", osc.Enable); else n_pass++;
    n_checks++; if (Overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", Overrun); else n_pass++;
    osc.Ready = 1'b1;
    @(negedge Fg_CLK);
    osc.Ready = 1'b0;
    n_checks++; if (Sample_Valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", Sample_Valid); else n_pass++;
    n_checks++; if (osc.Enable !== 1'b0) $display("FAIL ovr_enable_drop: got %b expected 0", osc.Enable); else n_pass++;
    repeat (5) @(negedge Fg_CLK);
    n_checks++; if (sv_count - sv1 !== 1) $display("FAIL ovr_single_valid: got %0d expected 1", sv_count - sv1); else n_pass++;
    n_checks++; if (Overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", Overrun); else n_pass++;
    ready_auto = 1'b1;
  endtask

`ifdef OSC_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    bit seen;
    ready_auto = 1'b0;
    for (int i = 0; i < 20 && osc.Enable === 1'b1; i++) @(negedge Fg_CLK);
    seen = 1'b0;
    for (int i = 0; i < (SETTLE_CNT + 2) * TICK_DIV && !seen; i++) begin
      @(negedge Fg_CLK);
      seen = (osc.Enable === 1'b1);
    end
    n_checks++; if (!seen) $display("FAIL wd_enable_timeout: got no enable expected 1"); else n_pass++;
    repeat (63) @(negedge Fg_CLK);
    n_checks++; if (Timeout !== 1'b0) $display("FAIL wd_early: got %b expected 0", Timeout); else n_pass++;
    exp_q.push_back({exp_mode, T_INIT1[exp_mode], T_INIT2[exp_mode]});
    @(negedge Fg_CLK);
    n_checks++; if (Timeout !== 1'b1) $display("FAIL wd_timeout: got %b expected 1", Timeout); else n_pass++;
    n_checks++; if (osc.Enable !== 1'b0) $display("FAIL wd_enable_drop: got %b expected 0", osc.Enable); else n_pass++;
    @(negedge Fg_CLK);
    n_checks++; if (osc.Load !== 1'b1) $display("FAIL wd_load: got %b expected 1", osc.Load); else n_pass++;
    n_checks++; if (Mode !== exp_mode) $display("FAIL wd_mode: got %0d expected %0d", Mode, exp_mode); else n_pass++;
    ready_auto = 1'b1;
  endtask
`endif

  task automatic test_btn_ready_same();
    int sv0;
    bit ok;
    wait_sv(sv_count + 1, (SETTLE_CNT + 2) * TICK_DIV, ok);
    n_checks++; if (!ok) $display("FAIL same_run_timeout: got no valid expected 1"); else n_pass++;
    ready_auto = 1'b0;
    wait_en(en_count + 1, TICK_DIV + 50, ok);
    n_checks++; if (!ok) $display("FAIL same_enable_timeout: got no enable expected 1"); else n_pass++;
    sv0 = sv_count;
    exp_mode = next_mode(exp_mode);
    exp_q.push_back({exp_mode, T_INIT1[exp_mode], T_INIT2[exp_mode]});
    IntBTN = 1'b1;
    osc.Ready = 1'b1;
    @(negedge Fg_CLK);
    IntBTN = 1'b0;
    osc.Ready = 1'b0;
    n_checks++; if (osc.Enable !== 1'b0) $display("FAIL same_enable: got %b expected 0", osc.Enable); else n_pass++;
    n_checks++; if (Sample_Valid !== 1'b0) $display("FAIL same_valid: got %b expected 0", Sample_Valid); else n_pass++;
    n_checks++; if (Mode !== exp_mode) $display("FAIL same_mode: got %0d expected %0d", Mode, exp_mode); else n_pass++;
    @(negedge Fg_CLK);
    n_checks++; if (osc.Load !== 1'b1) $display("FAIL same_load: got %b expected 1", osc.Load); else n_pass++;
    repeat (4) @(negedge Fg_CLK);
    n_checks++; if (sv_count !== sv0) $display("FAIL same_no_valid: got %0d valids expected 0", sv_count - sv0); else n_pass++;
    ready_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ready_auto = 1'b0;
    wait_en(en_count + 1, (SETTLE_CNT + 2) * TICK_DIV, ok);
    n_checks++; if (!ok) $display("FAIL mid_enable_timeout: got no enable expected 1"); else n_pass++;
    RESETn = 1'b0;
    @(negedge Fg_CLK);
    n_checks++; if (osc.Enable !== 1'b0) $display("FAIL mid_enable: got %b expected 0", osc.Enable); else n_pass++;
    n_checks++; if (Overrun !== 1'b0) $display("FAIL mid_overrun: got %b expected 0", Overrun); else n_pass++;
    n_checks++; if (Mode !== 4'd0) $display("FAIL mid_mode: got %0d expected 0", Mode); else n_pass++;
    n_checks++; if (osc.Init1 !== T_INIT1[0]) $display("FAIL mid_init1: got %0d expected %0d", osc.Init1, T_INIT1[0]); else n_pass++;
`ifdef OSC_SCHED_WATCHDOG_EN
    n_checks++; if (Timeout !== 1'b0) $display("FAIL mid_timeout: got %b expected 0", Timeout); else n_pass++;
`endif
    exp_mode = 4'd0;
    exp_q.push_back({4'd0, T_INIT1[0], T_INIT2[0]});
    RESETn = 1'b1;
    @(negedge Fg_CLK);
    n_checks++; if (osc.Load !== 1'b1) $display("FAIL mid_release_load: got %b expected 1", osc.Load); else n_pass++;
    ready_auto = 1'b1;
    repeat (10) @(negedge Fg_CLK);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    osc.Ready = 1'b0;
    test_reset();
    test_settle_run();
    test_button();
    test_lockout();
`ifdef OSC_SCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_overrun();
`endif
    test_btn_ready_same();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d pending loads expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
